// File: rtl/alu_sequencer.sv
// Command-side controller for a combinational ALU: single ops in one execute
// cycle, unsigned multiply by BUS shift-add iterations through the same ALU.
// Latency: single op rsp_valid 2 cycles after accept, multiply BUS+1 cycles.
// Backpressure: one command in flight; cmd_ready only in IDLE, RESP holds until rsp_ready.
//
// Ports:
//   clk, rst_n                 clock, synchronous active-low reset
//   cmd_valid/cmd_ready        command handshake; cmd_mul, cmd_fun, cmd_a, cmd_b payload
//   alu_a, alu_b, alu_fun      ALU inputs (driven only from internal state)
//   alu_s, alu_cnvz            ALU result and {C,N,V,Z} flags
//   rsp_valid/rsp_ready        response handshake; rsp_data, rsp_cnvz payload
module alu_sequencer #(
  parameter int BUS = 4
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic             cmd_mul,
  input  logic [3:0]       cmd_fun,
  input  logic [BUS-1:0]   cmd_a,
  input  logic [BUS-1:0]   cmd_b,
  output logic [BUS-1:0]   alu_a,
  output logic [BUS-1:0]   alu_b,
  output logic [3:0]       alu_fun,
  input  logic [BUS-1:0]   alu_s,
  input  logic [3:0]       alu_cnvz,
  output logic             rsp_valid,
  input  logic             rsp_ready,
  output logic [2*BUS-1:0] rsp_data,
  output logic [3:0]       rsp_cnvz
);

  localparam int CW = $clog2(BUS);

  typedef enum logic [1:0] {IDLE, EXEC, MUL, RESP} state_t;

  state_t             state, state_n;
  logic [BUS-1:0]     a_r, a_n;       // operand a / multiplicand
  logic [BUS-1:0]     b_r, b_n;       // operand b / multiplier M (low product half)
  logic [3:0]         fun_r, fun_n;
  logic [BUS-1:0]     p_hi, p_hi_n;   // upper product half
  logic [CW-1:0]      cnt, cnt_n;
  logic [2*BUS-1:0]   data_r, data_n;
  logic [3:0]         cnvz_r, cnvz_n;

  assign rsp_data = data_r;
  assign rsp_cnvz = cnvz_r;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state  <= IDLE;
      a_r    <= '0;
      b_r    <= '0;
      fun_r  <= '0;
      p_hi   <= '0;
      cnt    <= '0;
      data_r <= '0;
      cnvz_r <= '0;
    end else begin
      state  <= state_n;
      a_r    <= a_n;
      b_r    <= b_n;
      fun_r  <= fun_n;
      p_hi   <= p_hi_n;
      cnt    <= cnt_n;
      data_r <= data_n;
      cnvz_r <= cnvz_n;
    end
  end

  always_comb begin
    state_n   = state;
    a_n       = a_r;
    b_n       = b_r;
    fun_n     = fun_r;
    p_hi_n    = p_hi;
    cnt_n     = cnt;
    data_n    = data_r;
    cnvz_n    = cnvz_r;
    cmd_ready = 1'b0;
    rsp_valid = 1'b0;
    alu_a     = '0;
    alu_b     = '0;
    alu_fun   = '0;

    case (state)
      IDLE: begin
        cmd_ready = 1'b1;
        if (cmd_valid) begin
          a_n     = cmd_a;
          b_n     = cmd_b;
          fun_n   = cmd_fun;
          p_hi_n  = '0;
          cnt_n   = CW'(BUS - 1);
          state_n = cmd_mul ? MUL : EXEC;
        end
      end

      EXEC: begin
        alu_a   = a_r;
        alu_b   = b_r;
        alu_fun = fun_r;
        data_n  = {{BUS{1'b0}}, alu_s};
        cnvz_n  = alu_cnvz;
        state_n = RESP;
      end

      MUL: begin
        // P_hi + (M[0] ? A : 0), then shift {carry, sum, M} right by one.
        // The carry becomes the new MSB, so the add never loses a bit.
        alu_fun = 4'b1000;
        alu_a   = p_hi;
        alu_b   = b_r[0] ? a_r : '0;
        p_hi_n  = {alu_cnvz[3], alu_s[BUS-1:1]};
        b_n     = {alu_s[0], b_r[BUS-1:1]};
        if (cnt == '0) begin
          data_n  = {p_hi_n, b_n};
          // V flags a product that does not fit in BUS bits.
          cnvz_n  = {2'b00, |p_hi_n, ~|{p_hi_n, b_n}};
          state_n = RESP;
        end else begin
          cnt_n = cnt - 1'b1;
        end
      end

      RESP: begin
        rsp_valid = 1'b1;
        if (rsp_ready) state_n = IDLE;
      end

      default: state_n = IDLE;
    endcase
  end

endmodule

// File: tb/tb_alu_sequencer.sv
module tb_alu_sequencer;
  localparam int BUS = 4;

  logic             clk = 1'b0;
  logic             rst_n;
  logic             cmd_valid;
  logic             cmd_ready;
  logic             cmd_mul;
  logic [3:0]       cmd_fun;
  logic [BUS-1:0]   cmd_a;
  logic [BUS-1:0]   cmd_b;
  logic [BUS-1:0]   alu_a;
  logic [BUS-1:0]   alu_b;
  logic [3:0]       alu_fun;
  logic [BUS-1:0]   alu_s;
  logic [3:0]       alu_cnvz;
  logic             rsp_valid;
  logic             rsp_ready;
  logic [2*BUS-1:0] rsp_data;
  logic [3:0]       rsp_cnvz;

  always #5 clk = ~clk;

  alu_sequencer #(.BUS(BUS)) dut (
    .clk(clk), .rst_n(rst_n),
    .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_mul(cmd_mul),
    .cmd_fun(cmd_fun), .cmd_a(cmd_a), .cmd_b(cmd_b),
    .alu_a(alu_a), .alu_b(alu_b), .alu_fun(alu_fun),
    .alu_s(alu_s), .alu_cnvz(alu_cnvz),
    .rsp_valid(rsp_valid), .rsp_ready(rsp_ready),
    .rsp_data(rsp_data), .rsp_cnvz(rsp_cnvz)
  );

  // Behavioural ALU: returns {C,N,V,Z, s}. Logic and shift ops report only Z.
  function automatic logic [7:0] alu_ref(input logic [3:0] f, input logic [3:0] a, input logic [3:0] b);
    logic [4:0] t;
    logic [3:0] bb, s;
    logic       c, n, v;
    c = 1'b0; n = 1'b0; v = 1'b0; bb = b; t = '0;
    if (f[3]) begin
      bb = f[0] ? ~b : b;
      t  = {1'b0, a} + {1'b0, bb} + {4'b0, f[0]};
      s  = t[3:0];
      c  = t[4];
      n  = s[3];
      v  = (a[3] == bb[3]) && (s[3] != a[3]);
    end else if (f[2]) begin
      case (f[1:0])
        2'b00:   s = a | b;
        2'b01:   s = a & b;
        2'b10:   s = a ^ b;
        default: s = ~a;
      endcase
    end else begin
      if (f[0])      s = {a[2:0], 1'b0};
      else if (f[1]) s = {a[3], a[3:1]};
      else           s = {1'b0, a[3:1]};
    end
    return {c, n, v, (s == 4'd0), s};
  endfunction

  // Expected {cnvz, data} for a command.
  function automatic logic [11:0] golden(input logic mul, input logic [3:0] f, input logic [3:0] a, input logic [3:0] b);
    logic [7:0] p, r;
    if (mul) begin
      p = {4'b0, a} * {4'b0, b};
      return {2'b00, |p[7:4], (p == 8'd0), p};
    end
    r = alu_ref(f, a, b);
    return {r[7:4], 4'b0, r[3:0]};
  endfunction

  always_comb {alu_cnvz, alu_s} = alu_ref(alu_fun, alu_a, alu_b);

  int total = 0;
  int bad   = 0;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  task automatic step;
    @(posedge clk);
    #1;
  endtask

  typedef struct {
    logic       mul;
    logic [3:0] fun;
    logic [3:0] a;
    logic [3:0] b;
    logic [7:0] data;
    logic [3:0] cnvz;
    int         lat;
  } vec_t;

  vec_t vt[8];

  // Called at #1 after an edge with the DUT in IDLE; returns one cycle after accept.
  task automatic issue(input logic mul, input logic [3:0] f, input logic [3:0] a, input logic [3:0] b);
    cmd_valid = 1'b1; cmd_mul = mul; cmd_fun = f; cmd_a = a; cmd_b = b;
    step;
    cmd_valid = 1'b0;
  endtask

  task automatic run(input vec_t v, input string tag);
    int n;
    issue(v.mul, v.fun, v.a, v.b);
    chk({tag, " busy"}, 32'(cmd_ready), 32'd0);
    n = 0;
    while (!rsp_valid && n < 20) begin
      step;
      n++;
    end
    chk({tag, " latency"}, 32'(n + 1), 32'(v.lat));
    chk({tag, " data"}, 32'(rsp_data), 32'(v.data));
    chk({tag, " cnvz"}, 32'(rsp_cnvz), 32'(v.cnvz));
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
    chk({tag, " idle"}, {30'd0, rsp_valid, cmd_ready}, 32'b01);
  endtask

  logic [3:0]  bb_fun[8], bb_a[8], bb_b[8];
  logic        bb_mul[8];
  logic [11:0] bb_exp[8];

  initial begin
    logic [7:0] held_d;
    logic [3:0] held_f;
    vec_t       v;
    int         issued, recv, cyc;

    vt[0] = '{1'b0, 4'b1000, 4'd7,  4'd9,  8'h00, 4'b1001, 2};
    vt[1] = '{1'b0, 4'b1001, 4'd3,  4'd5,  8'h0E, 4'b0100, 2};
    vt[2] = '{1'b0, 4'b0110, 4'hA,  4'h6,  8'h0C, 4'b0000, 2};
    vt[3] = '{1'b0, 4'b0101, 4'hC,  4'hA,  8'h08, 4'b0000, 2};
    vt[4] = '{1'b0, 4'b0001, 4'h9,  4'h0,  8'h02, 4'b0000, 2};
    vt[5] = '{1'b1, 4'b0000, 4'd15, 4'd15, 8'hE1, 4'b0010, 5};
    vt[6] = '{1'b1, 4'b0000, 4'd0,  4'd9,  8'h00, 4'b0001, 5};
    vt[7] = '{1'b1, 4'b0011, 4'd3,  4'd2,  8'h06, 4'b0000, 5};

    rst_n = 1'b0; cmd_valid = 1'b0; cmd_mul = 1'b0; cmd_fun = '0;
    cmd_a = '0; cmd_b = '0; rsp_ready = 1'b0;
    step; step;
    rst_n = 1'b1;
    chk("reset outputs", {cmd_ready, rsp_valid, rsp_data, rsp_cnvz, alu_a, alu_b, alu_fun},
        {1'b1, 1'b0, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0});

    for (int i = 0; i < 8; i++) run(vt[i], $sformatf("vec%0d", i));

    // Multiplier for an 8x2 product overflowing BUS bits.
    v = '{1'b1, 4'b0000, 4'd8, 4'd2, 8'h10, 4'b0010, 5};
    run(v, "mul 8x2");

    // Backpressure: response held, a stray command is ignored.
    issue(1'b0, 4'b1000, 4'd2, 4'd3);
    cyc = 0;
    while (!rsp_valid && cyc < 20) begin step; cyc++; end
    held_d = rsp_data;
    held_f = rsp_cnvz;
    chk("bp data", 32'(held_d), 32'h05);
    chk("bp cnvz", 32'(held_f), 32'h0);
    for (int i = 0; i < 3; i++) begin
      cmd_valid = (i == 1); cmd_mul = 1'b1; cmd_a = 4'd5; cmd_b = 4'd5;
      step;
      cmd_valid = 1'b0;
      chk($sformatf("bp hold %0d", i), {rsp_valid, cmd_ready, rsp_data, rsp_cnvz},
          {1'b1, 1'b0, held_d, held_f});
    end
    rsp_ready = 1'b1;
    step;
    rsp_ready = 1'b0;
    chk("bp release ready", 32'(cmd_ready), 32'd1);
    step; step; step;
    chk("bp stray not queued", {30'd0, rsp_valid, cmd_ready}, 32'b01);

    // Reset in the second multiply cycle.
    issue(1'b1, 4'b0000, 4'd15, 4'd15);
    step;
    chk("mul in progress", 32'(alu_fun), 32'b1000);
    rst_n = 1'b0;
    step;
    rst_n = 1'b1;
    chk("mid-mul reset", {cmd_ready, rsp_valid, rsp_data, rsp_cnvz, alu_a, alu_b, alu_fun},
        {1'b1, 1'b0, 8'h00, 4'h0, 4'h0, 4'h0, 4'h0});
    v = '{1'b0, 4'b1000, 4'd1, 4'd1, 8'h02, 4'b0000, 2};
    run(v, "add after reset");

    // Back-to-back with cmd_valid and rsp_ready held high.
    for (int i = 0; i < 8; i++) begin
      bb_mul[i] = 1'($urandom_range(0, 1));
      bb_fun[i] = 4'($urandom_range(0, 15));
      bb_a[i]   = 4'($urandom_range(0, 15));
      bb_b[i]   = 4'($urandom_range(0, 15));
      bb_exp[i] = golden(bb_mul[i], bb_fun[i], bb_a[i], bb_b[i]);
    end
    issued = 0; recv = 0; cyc = 0;
    rsp_ready = 1'b1;
    while (recv < 8 && cyc < 200) begin
      cmd_valid = (issued < 8);
      if (issued < 8) begin
        cmd_mul = bb_mul[issued]; cmd_fun = bb_fun[issued];
        cmd_a = bb_a[issued]; cmd_b = bb_b[issued];
      end
      if (rsp_valid) begin
        chk($sformatf("b2b rsp%0d", recv), {20'd0, rsp_cnvz, rsp_data}, 32'(bb_exp[recv]));
        recv++;
      end
      if (cmd_valid && cmd_ready) issued++;
      step;
      cyc++;
    end
    cmd_valid = 1'b0;
    rsp_ready = 1'b0;
    chk("b2b response count", 32'(recv), 32'd8);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
